// File: rtl/subband_packer.sv
// Ping-pong row buffer: takes L/H pairs, re-emits each row as all L words then all H words.
// First word is valid the cycle after the last pair of a row is accepted; in_ready drops only when both banks are full.
module subband_packer #(
  parameter int PAIRS = 32,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_L,
  input  logic [DW-1:0] in_H,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_band,
  output logic          out_last,
  input  logic          out_ready
);
  localparam int AW = $clog2(PAIRS);

  logic [DW-1:0] mem_l [2][PAIRS];
  logic [DW-1:0] mem_h [2][PAIRS];

  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wsel;
  logic          rsel;
  logic [AW-1:0] wptr;
  logic [AW:0]   rptr;
  logic          wr_en;
  logic          wr_done;
  logic          rd_en;
  logic          rd_done;
  logic [AW-1:0] ridx;

  assign in_ready  = !full[wsel];
  assign wr_en     = in_valid && in_ready;
  assign wr_done   = wr_en && (wptr == AW'(PAIRS - 1));
  assign out_valid = full[rsel];
  assign out_last  = out_valid && (rptr == (AW + 1)'(2 * PAIRS - 1));
  assign rd_en     = out_valid && out_ready;
  assign rd_done   = rd_en && out_last;
  assign ridx      = rptr[AW-1:0];

  // PAIRS is a power of two, so the top bit of rptr is the band select.
  always_comb begin
    out_data = '0;
    out_band = 1'b0;
    if (out_valid) begin
      out_band = rptr[AW];
      out_data = rptr[AW] ? mem_h[rsel][ridx] : mem_l[rsel][ridx];
    end
  end

  // Writer and reader never own the same bank when both act on one edge.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wsel] = 1'b1;
    if (rd_done) full_nxt[rsel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_l[wsel][wptr] <= in_L;
      mem_h[wsel][wptr] <= in_H;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
      wsel <= 1'b0;
      rsel <= 1'b0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      full <= full_nxt;
      if (wr_en)   wptr <= wptr + 1'b1;
      if (wr_done) wsel <= ~wsel;
      if (rd_en)   rptr <= rptr + 1'b1;
      if (rd_done) rsel <= ~rsel;
    end
  end

endmodule

// File: tb/tb_subband_packer.sv
// Directed bench for subband_packer: reset, single row, streaming, stalls, ignored input, mid-row resets.
module tb_subband_packer;
  localparam int PAIRS = 32;
  localparam int DW    = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_L;
  logic [DW-1:0] in_H;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_band;
  logic          out_last;
  logic          out_ready;

  int checks = 0;
  int errors = 0;

  logic [15:0] src_q [$];
  logic [9:0]  exp_q [$];
  logic        held_vld = 1'b0;
  logic [9:0]  held_w   = '0;

  subband_packer #(.PAIRS(PAIRS), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_L      (in_L),
    .in_H      (in_H),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_band  (out_band),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: L=i H=100+i; mode 1: L=FF-i H=i; mode 2: random
  task automatic load_row(input int mode);
    logic [7:0] l [PAIRS];
    logic [7:0] h [PAIRS];
    for (int i = 0; i < PAIRS; i++) begin
      case (mode)
        0:       begin l[i] = 8'(i);         h[i] = 8'(100 + i); end
        1:       begin l[i] = 8'(255 - i);   h[i] = 8'(i);       end
        default: begin l[i] = 8'($urandom);  h[i] = 8'($urandom); end
      endcase
      src_q.push_back({l[i], h[i]});
    end
    for (int i = 0; i < PAIRS; i++) exp_q.push_back({1'b0, 1'b0, l[i]});
    for (int i = 0; i < PAIRS; i++) exp_q.push_back({(i == PAIRS - 1), 1'b1, h[i]});
  endtask

  // One cycle: drive inputs, check outputs against the scoreboard, advance past the edge.
  // rm: 0 = out_ready low, 1 = high, 2 = random.
  task automatic step(input int rm);
    logic [9:0] w;
    out_ready = (rm == 2) ? 1'($urandom_range(0, 1)) : (rm == 1);
    if (src_q.size() > 0) begin
      in_valid = 1'b1;
      {in_L, in_H} = src_q[0];
    end else begin
      in_valid = 1'b0;
      in_L = 8'($urandom);
      in_H = 8'($urandom);
    end
    if (held_vld) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_word", 32'({out_last, out_band, out_data}), 32'(held_w));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_word", 32'(out_valid), 32'd0);
      else begin
        w = exp_q.pop_front();
        chk("word", 32'({out_last, out_band, out_data}), 32'(w));
      end
    end
    held_vld = out_valid && !out_ready;
    held_w   = {out_last, out_band, out_data};
    if (in_valid && in_ready) void'(src_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int rm, input string tag);
    for (int k = 0; k < 1000 && (exp_q.size() > 0 || src_q.size() > 0); k++) step(rm);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_sb();
    src_q.delete();
    exp_q.delete();
    held_vld = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with random inputs
    rst_n     = 1'b0;
    in_valid  = 1'($urandom_range(0, 1));
    in_L      = 8'($urandom);
    in_H      = 8'($urandom);
    out_ready = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_band", 32'(out_band), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single row; first word appears the cycle after the 32nd accept
    load_row(0);
    repeat (PAIRS - 1) step(1);
    chk("pre_fill_valid", 32'(out_valid), 32'd0);
    step(1);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_word", 32'({out_band, out_data}), 32'h000);
    repeat (2 * PAIRS) step(1);
    chk("row1_empty", 32'(exp_q.size()), 32'd0);
    chk("row1_idle", 32'(out_valid), 32'd0);

    // Three rows streamed back to back
    load_row(2);
    load_row(2);
    load_row(2);
    repeat (2 * PAIRS) step(1);
    chk("in_ready_fall", 32'(in_ready), 32'd0);
    repeat (PAIRS - 1) step(1);
    chk("row_a_last", 32'(out_last), 32'd1);
    chk("row_a_last_rdy", 32'(in_ready), 32'd0);
    step(1);
    chk("in_ready_return", 32'(in_ready), 32'd1);
    drain(1, "stream_done");

    // Random output backpressure over two rows
    load_row(0);
    load_row(2);
    drain(2, "stall_done");
    chk("stall_idle", 32'(out_valid), 32'd0);

    // Ignored input while both banks are full
    load_row(2);
    load_row(1);
    repeat (2 * PAIRS) step(0);
    chk("both_full_rdy", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_L      = (k % 2 == 0) ? 8'hAA : 8'h55;
      in_H      = (k % 2 == 0) ? 8'h55 : 8'hAA;
      chk("blocked_rdy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    held_vld = 1'b0;
    in_valid = 1'b0;
    drain(1, "blocked_done");
    chk("blocked_idle", 32'(out_valid), 32'd0);

    // Reset after 10 pairs of a row
    load_row(2);
    repeat (10) step(1);
    rst_n = 1'b0;
    #1;
    chk("rst1_in_ready", 32'(in_ready), 32'd1);
    chk("rst1_out_valid", 32'(out_valid), 32'd0);
    clear_sb();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-drain of a full row
    load_row(2);
    repeat (PAIRS) step(0);
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    repeat (20) step(1);
    rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_out_data", 32'(out_data), 32'd0);
    chk("rst2_out_band", 32'(out_band), 32'd0);
    chk("rst2_out_last", 32'(out_last), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    clear_sb();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fresh row after reset, no stale words
    load_row(1);
    drain(1, "fresh_done");
    chk("fresh_idle", 32'(out_valid), 32'd0);
    repeat (4) step(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
